// File: rtl/mult_norm_round.sv
// Post-multiply normalize/round stage: takes a 2*SW-bit significand product and an
// exponent sum, normalizes by 0/1 bit, rounds to nearest-even, and classifies the result.
module mult_norm_round #(
  parameter int SW = 24,
  parameter int EW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              ack_i,
  input  logic [2*SW-1:0]   sgf_prod_i,
  input  logic [EW+1:0]     exp_i,
  output logic [SW-2:0]     sgf_o,
  output logic [EW-1:0]     exp_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              busy_o,
  output logic              ready_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [EW+1:0] ONE     = (EW+2)'(1);
  localparam logic signed [EW+1:0] ZERO    = '0;
  localparam logic signed [EW+1:0] EXP_MAX = (EW+2)'((1 << EW) - 1);

  // Handshake: start_i is a one-cycle strobe honoured only in IDLE; ready_o is high
  // only in DONE and the result is held until ack_i is sampled there.
  logic [1:0]             state;
  logic [2*SW-1:0]        p;
  logic signed [EW+1:0]   e;
  logic [SW-1:0]          m;
  logic                   g;
  logic                   s;
  logic                   z;

  logic                   inc;
  logic [SW:0]            sum;
  logic signed [EW+1:0]   e_rnd;
  logic [SW-2:0]          frac;

  // Carry out of the rounding add means the significand became 2.0: fraction is zero.
  always_comb begin
    inc   = g & (s | m[0]);
    sum   = {1'b0, m} + {{SW{1'b0}}, inc};
    e_rnd = sum[SW] ? (e + ONE) : e;
    frac  = sum[SW] ? '0 : sum[SW-2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      p           <= '0;
      e           <= '0;
      m           <= '0;
      g           <= 1'b0;
      s           <= 1'b0;
      z           <= 1'b0;
      sgf_o       <= '0;
      exp_o       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            p     <= sgf_prod_i;
            e     <= $signed(exp_i);
            state <= NORM;
          end
        end
        NORM: begin
          if (p[2*SW-1]) begin
            m <= p[2*SW-1:SW];
            g <= p[SW-1];
            s <= |p[SW-2:0];
            e <= e + ONE;
          end else begin
            m <= p[2*SW-2:SW-1];
            g <= p[SW-2];
            s <= |p[SW-3:0];
          end
          z     <= (p == '0);
          state <= ROUND;
        end
        ROUND: begin
          if (z) begin
            sgf_o       <= '0;
            exp_o       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
          end else if (e_rnd >= EXP_MAX) begin
            sgf_o       <= '0;
            exp_o       <= '1;
            overflow_o  <= 1'b1;
            underflow_o <= 1'b0;
          end else if (e_rnd <= ZERO) begin
            sgf_o       <= '0;
            exp_o       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b1;
          end else begin
            sgf_o       <= frac;
            exp_o       <= e_rnd[EW-1:0];
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (ack_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state != IDLE);
  assign ready_o = (state == DONE);
  assign state_o = state;

endmodule

// File: tb/tb_mult_norm_round.sv
// Bench for mult_norm_round: directed corner cases plus randomized products checked
// against an integer-arithmetic round-to-nearest-even model.
module tb_mult_norm_round;
  localparam int SW = 24;
  localparam int EW = 8;
  localparam int RW = 2 + EW + SW - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              ack_i;
  logic [2*SW-1:0]   sgf_prod_i;
  logic [EW+1:0]     exp_i;
  logic [SW-2:0]     sgf_o;
  logic [EW-1:0]     exp_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              busy_o;
  logic              ready_o;
  logic [1:0]        state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];

  mult_norm_round #(.SW(SW), .EW(EW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i),
    .sgf_prod_i(sgf_prod_i), .exp_i(exp_i), .sgf_o(sgf_o), .exp_o(exp_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .busy_o(busy_o),
    .ready_o(ready_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
  endtask

  // Exact integer rounding: quotient/remainder against half an ulp.
  function automatic logic [RW-1:0] ref_model(input bit [63:0] prod, input int ein);
    bit [63:0] q, rem, half;
    bit [SW-2:0] fr;
    bit [EW-1:0] ex;
    bit ov, un;
    int sh, e;
    fr = '0; ex = '0; ov = 1'b0; un = 1'b0;
    if (prod != 0) begin
      sh   = (prod >= (64'd1 << (2*SW-1))) ? SW : SW - 1;
      e    = ein + ((sh == SW) ? 1 : 0);
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << SW)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= (1 << EW) - 1) begin
        ov = 1'b1; ex = '1;
      end else if (e <= 0) begin
        un = 1'b1;
      end else begin
        fr = q[SW-2:0];
        ex = e[EW-1:0];
      end
    end
    return {ov, un, ex, fr};
  endfunction

  task automatic check_result(input string tag, input logic [RW-1:0] r);
    check({tag, "_sgf"}, 64'(sgf_o), 64'(r[SW-2:0]));
    check({tag, "_exp"}, 64'(exp_o), 64'(r[SW-1+:EW]));
    check({tag, "_unf"}, 64'(underflow_o), 64'(r[RW-2]));
    check({tag, "_ovf"}, 64'(overflow_o), 64'(r[RW-1]));
  endtask

  task automatic issue(input logic [2*SW-1:0] prod, input int ein);
    @(negedge clk);
    start_i    = 1'b1;
    sgf_prod_i = prod;
    exp_i      = ein[EW+1:0];
    exp_q.push_back(ref_model(64'(prod), ein));
    @(negedge clk);
    start_i    = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 1;
    while (!ready_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    check("ack_ready", 64'(ready_o), 64'd0);
    check("ack_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2*SW-1:0] prod, input int ein);
    int lat;
    logic [RW-1:0] r;
    issue(prod, ein);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    wait_ready(lat);
    check({tag, "_latency"}, 64'(lat), 64'd3);
    r = exp_q.pop_front();
    check_result(tag, r);
    do_ack();
  endtask

  initial begin
    int lat;
    logic [RW-1:0] r;
    logic [SW-1:0] a, b;
    logic [2*SW-1:0] prod;
    int ein;

    rst = 1'b1; start_i = 1'b0; ack_i = 1'b0; sgf_prod_i = '0; exp_i = '0;
    repeat (3) @(negedge clk);
    check("rst_sgf", 64'(sgf_o), 64'd0);
    check("rst_exp", 64'(exp_o), 64'd0);
    check("rst_flags", 64'({overflow_o, underflow_o}), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("one_x_one", 48'h400000000000, 127);
    run_op("norm_shift", 48'h900000000000, 127);
    run_op("carry_out", 48'h7FFFFFC00000, 100);
    run_op("tie_even", 48'h400000400000, 127);
    run_op("tie_odd", 48'h400000C00000, 127);
    run_op("overflow", 48'h800000000000, 254);
    run_op("underflow", 48'h400000000000, 0);
    run_op("zero", 48'h000000000000, 127);
    run_op("edge_max", 48'h400000000000, 254);
    run_op("edge_min", 48'h400000000000, 1);

    // Hold ack off: outputs and ready_o must stay put.
    issue(48'h900000000000, 130);
    wait_ready(lat);
    r = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("hold_ready", 64'(ready_o), 64'd1);
      check_result("hold", r);
      @(negedge clk);
    end
    do_ack();

    // start_i while busy: ignored in NORM and in DONE.
    issue(48'h600000000000, 120);
    start_i = 1'b1; sgf_prod_i = 48'hC00000000000; exp_i = 10'd50;
    @(negedge clk);
    start_i = 1'b0;
    wait_ready(lat);
    r = exp_q.pop_front();
    check_result("busy_start", r);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_start_done_ready", 64'(ready_o), 64'd1);
    check_result("busy_start_done", r);
    do_ack();
    @(negedge clk);
    check("busy_start_noqueue", 64'(busy_o), 64'd0);
    run_op("after_busy", 48'hC00000000000, 50);

    // start_i with ack_i in DONE: ack wins, no capture, outputs retained.
    issue(48'h500000000000, 140);
    wait_ready(lat);
    r = exp_q.pop_front();
    check_result("start_ack_pre", r);
    start_i = 1'b1; ack_i = 1'b1; sgf_prod_i = 48'h800000000000; exp_i = 10'd10;
    @(negedge clk);
    start_i = 1'b0; ack_i = 1'b0;
    check("start_ack_ready", 64'(ready_o), 64'd0);
    check("start_ack_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    check("start_ack_nocapture", 64'(busy_o), 64'd0);
    check_result("start_ack_retain", r);

    // Reset while in ROUND.
    issue(48'h900000000000, 127);
    @(negedge clk);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("midrst_sgf", 64'(sgf_o), 64'd0);
    check("midrst_exp", 64'(exp_o), 64'd0);
    check("midrst_flags", 64'({overflow_o, underflow_o}), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 48'h400000000000, 127);

    // Randomized products of normalized operands, with some forced ties and zeros.
    for (int i = 0; i < 60; i++) begin
      a = {1'b1, 23'($urandom)};
      b = {1'b1, 23'($urandom)};
      prod = a * b;
      case ($urandom_range(5, 0))
        0: prod = prod & ~48'h3FFFFF;
        1: prod = prod & ~48'h7FFFFF;
        2: if ($urandom_range(3, 0) == 0) prod = '0;
        default: ;
      endcase
      ein = int'($urandom_range(400, 0)) - 60;
      run_op("rand", prod, ein);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
